// File: rtl/ram_bist_ctrl_if.sv
// RAM pin bundle between the BIST controller (master) and the single-port RAM (slave).
// Controller drives SEL/Din/Addr; the RAM returns Dout one cycle after a read address.
interface ram_bist_ctrl_if #(
    parameter int ADDR_LENGTH = 2,
    parameter int DATA_LENGTH = 4
);
    logic                   mem_sel;
    logic [DATA_LENGTH-1:0] mem_din;
    logic [ADDR_LENGTH-1:0] mem_addr;
    logic [DATA_LENGTH-1:0] mem_dout;

    modport master (output mem_sel, output mem_din, output mem_addr, input mem_dout);
    modport slave  (input mem_sel, input mem_din, input mem_addr, output mem_dout);
endinterface

// File: rtl/ram_bist_ctrl.sv
// March-free BIST controller: writes seed ^ addr to every RAM location, reads it all back,
// and reports pass/fail, mismatch count and the first failing address.
module ram_bist_ctrl #(
    parameter int ADDR_LENGTH = 2,
    parameter int DATA_LENGTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    // start is a one-cycle request honoured only in IDLE or DONE; done is a level that
    // stays high until the next accepted start or reset (no ready/valid back-pressure).
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] seed,
    ram_bist_ctrl_if.master        mem,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ADDR_LENGTH:0]   err_count,
    output logic [ADDR_LENGTH-1:0] first_err_addr,
    output logic [2:0]             state
);
    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'((1 << ADDR_LENGTH) - 1);
    localparam logic [ADDR_LENGTH:0]   ERR_ONE   = (ADDR_LENGTH+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0] seed_q;
    logic                   cmp_v;
    logic [ADDR_LENGTH-1:0] cmp_a;
    logic                   start_acc;
    logic                   mismatch;

    function automatic logic [DATA_LENGTH-1:0] pattern(input logic [DATA_LENGTH-1:0] s,
                                                       input logic [ADDR_LENGTH-1:0] a);
        return s ^ DATA_LENGTH'(a);
    endfunction

    assign state     = state_q;
    assign mismatch  = cmp_v && (mem.mem_dout != pattern(seed_q, cmp_a));
    assign pass      = (state_q == S_DONE) && (err_count == '0);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        start_acc    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        mem.mem_sel  = 1'b0;
        mem.mem_din  = '0;
        mem.mem_addr = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    start_acc = 1'b1;
                    addr_d    = '0;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                busy         = 1'b1;
                mem.mem_sel  = 1'b1;
                mem.mem_addr = addr_q;
                mem.mem_din  = pattern(seed_q, addr_q);
                addr_d       = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = S_READ;
            end
            S_READ: begin
                busy         = 1'b1;
                mem.mem_addr = addr_q;
                addr_d       = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Last read's data arrives now; compare it before reporting.
                busy    = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            seed_q         <= '0;
            cmp_v          <= 1'b0;
            cmp_a          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cmp_v   <= (state_q == S_READ);
            cmp_a   <= addr_q;
            if (start_acc) begin
                seed_q         <= seed;
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (mismatch) begin
                err_count <= err_count + ERR_ONE;
                if (err_count == '0) first_err_addr <= cmp_a;
            end
        end
    end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural RAM that can inject stuck-at faults.
module tb_ram_bist_ctrl;
    localparam int AL = 2;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DL-1:0] seed = '0;
    logic          busy, done, pass;
    logic [AL:0]   err_count;
    logic [AL-1:0] first_err_addr;
    logic [2:0]    state;

    int n_checks = 0;
    int n_errors = 0;
    int fault_mode = 0;
    logic [31:0] exp_q[$];

    ram_bist_ctrl_if #(.ADDR_LENGTH(AL), .DATA_LENGTH(DL)) bus ();

    ram_bist_ctrl #(.ADDR_LENGTH(AL), .DATA_LENGTH(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .mem(bus),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .state(state)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, faults applied on the read path
    logic [DL-1:0] ram [4];
    always @(posedge clk) begin
        if (bus.mem_sel) begin
            ram[bus.mem_addr] <= bus.mem_din;
        end else begin
            case (fault_mode)
                1:       bus.mem_dout <= (bus.mem_addr == 2'd2) ? (ram[bus.mem_addr] | 4'b0001)
                                                                : ram[bus.mem_addr];
                2:       bus.mem_dout <= ram[bus.mem_addr] & 4'b0111;
                default: bus.mem_dout <= ram[bus.mem_addr];
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Write monitor: every RAM write must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && bus.mem_sel === 1'b1) begin
            if (exp_q.size() == 0) check("extra_write", {26'd0, bus.mem_addr, bus.mem_din}, 32'hffff_ffff);
            else check("write", {26'd0, bus.mem_addr, bus.mem_din}, exp_q.pop_front());
        end else if (!reset) begin
            check("din_idle", {28'd0, bus.mem_din}, 32'd0);
        end
    end

    task automatic push_writes(input logic [DL-1:0] s);
        for (int a = 0; a < 4; a++) begin
            logic [AL-1:0] aa;
            logic [DL-1:0] d;
            aa = AL'(a);
            d  = s ^ DL'(a);
            exp_q.push_back({26'd0, aa, d});
        end
    endtask

    // Pulse start (optionally held into WRITE), then wait for done and check the report
    task automatic run(input logic [DL-1:0] s, input bit hold_start, input int exp_pass,
                       input int exp_err, input int exp_first);
        int cycles;
        push_writes(s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_drop", {31'd0, done}, 32'd0);
        if (!hold_start) start = 1'b0;
        cycles = 0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (done) break;
        end
        check("done_latency", cycles, 32'd9);
        check("pass", {31'd0, pass}, exp_pass);
        check("err_count", {29'd0, err_count}, exp_err);
        check("first_err_addr", {30'd0, first_err_addr}, exp_first);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("state_done", {29'd0, state}, 32'd4);
        check("writes_seen", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_outputs", {26'd0, busy, done, pass, bus.mem_sel, bus.mem_addr}, 32'd0);
        check("rst_din", {28'd0, bus.mem_din}, 32'd0);
        check("rst_err", {26'd0, err_count, first_err_addr}, 32'd0);
        reset = 1'b0;

        fault_mode = 0;
        run(4'b1010, 1'b0, 1, 0, 0);
        fault_mode = 1;
        run(4'b1010, 1'b0, 0, 1, 2);
        fault_mode = 2;
        run(4'b1111, 1'b0, 0, 4, 0);
        fault_mode = 0;
        run(4'b0110, 1'b1, 1, 0, 0);
        run(4'b0000, 1'b0, 1, 0, 0);
        repeat (3) @(negedge clk);
        check("done_held", {31'd0, done}, 32'd1);

        // Reset during READ aborts the run
        push_writes(4'b0101);
        seed  = 4'b0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("in_read", {29'd0, state}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_flags", {29'd0, busy, done, bus.mem_sel}, 32'd0);
        check("abort_err", {29'd0, err_count}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        run(4'b0011, 1'b0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Initiator-side controller for the team's single-port synchronous RAM (SEL=1 write, SEL=0 registered read, one-cycle read latency).
- On a start pulse it writes a seed-derived pattern to every location, reads every location back, compares, and reports pass/fail, error count and first failing address.
- Sits beside the RAM and drives its SEL/Din/Addr pins. It consumes the RAM's Dout.

Parameters:
- ADDR_LENGTH, 2, RAM address width; DEPTH = 2**ADDR_LENGTH locations.
- DATA_LENGTH, 4, RAM data width.

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  begin test; sampled only in IDLE or DONE
- seed  input  DATA_LENGTH  pattern seed, latched when start is accepted
- mem_sel  output  1  to RAM SEL; 1=write, 0=read
- mem_din  output  DATA_LENGTH  to RAM Din
- mem_addr  output  ADDR_LENGTH  to RAM Addr
- mem_dout  input  DATA_LENGTH  from RAM Dout; valid the cycle after a read address is presented
- busy  output  1  high in WRITE, READ, DRAIN
- done  output  1  high in DONE; held until the next start or reset
- pass  output  1  valid when done=1: 1 iff err_count==0
- err_count  output  ADDR_LENGTH+1  number of mismatching locations; max DEPTH, no overflow
- first_err_addr  output  ADDR_LENGTH  address of the first mismatch; 0 if none

Behaviour:
- Reset (synchronous, active-high): state=IDLE, addr counter=0, seed_q=0, err_count=0, first_err_addr=0, pass=0, done=0, busy=0, mem_sel=0, mem_din=0, mem_addr=0.
- Pattern: exp(a) = seed_q XOR zero-extend(a) to DATA_LENGTH. If ADDR_LENGTH>DATA_LENGTH, a is truncated to its low bits.
- States: IDLE, WRITE, READ, DRAIN, DONE. Outputs are decoded from registered state and counter.
- IDLE/DONE, start=1: latch seed, clear err_count/first_err_addr/pass/done, addr=0, go to WRITE.
- WRITE:
  - mem_sel=1, mem_addr=a, mem_din=exp(a); a increments each cycle.
  - At the edge where a=DEPTH-1: a wraps to 0 and the state goes to READ.
- READ:
  - mem_sel=0, mem_addr=a; a increments each cycle.
  - A one-bit pipeline flag cmp_v and a register cmp_a track the address issued last cycle.
  - At the edge where a=DEPTH-1: go to DRAIN.
- DRAIN: mem_sel=0, mem_addr=0. Compares the last location, then goes to DONE.
- Compare: in any cycle with cmp_v=1, if mem_dout != exp(cmp_a):
  - err_count increments at the next edge;
  - if this is the first error of the run, first_err_addr <= cmp_a.
- DONE: busy=0, done=1, pass=(err_count==0), mem_sel=0, mem_addr=0.
- Timing: start accepted at edge E0 → writes at E1..E_DEPTH → DONE entered at edge E(2*DEPTH+1). For DEPTH=4, done is visible after 9 edges.
- start while busy is ignored. start in DONE restarts immediately; done drops at the same edge.
- Reset mid-operation aborts the run: mem_sel=0 after that edge and no further RAM writes occur. RAM contents are left as-is.
- mem_din is 0 outside WRITE.

Test Plan:
- Reset held 2 cycles → all outputs 0, state IDLE, mem_sel=0.
- Good RAM model, seed=4'b1010, start pulse →
  - writes observed: addr0..3 = 1010, 1011, 1000, 1001;
  - done=1 nine cycles after start, pass=1, err_count=0, first_err_addr=0.
- RAM model with bit0 of addr2 stuck-at-1, seed=1010 → read 1001 vs expected 1000; done with pass=0, err_count=1, first_err_addr=2.
- RAM model with bit3 stuck-at-0 everywhere, seed=4'b1111 → err_count=4, first_err_addr=0, pass=0.
- start pulsed during WRITE → ignored, run completes normally. start pulsed in DONE with seed=0000 → done drops next cycle, new writes 0000, 0001, 0010, 0011.
- Reset asserted during READ → next cycle IDLE, busy=0, done=0, mem_sel=0. A following start completes with pass=1 on a good RAM.
